// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared widths and FSM state encoding for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;
   localparam int N_REQ  = 8;
   localparam int ID_W   = 3;
   localparam int HOLD_W = 8;
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_arbiter8_pick.sv
// rr_pick8: rotating priority pick; the first set req bit at or after ptr wins.
module rr_pick8
   import rr_arbiter8_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] pick,
   output logic [ID_W-1:0]  pick_id,
   output logic             any
);
   logic [2*N_REQ-1:0] w_dbl;
   logic [N_REQ-1:0]   w_rot;
   logic [ID_W-1:0]    w_idx;
   assign w_dbl = {req, req} >> ptr;
   assign w_rot = w_dbl[N_REQ-1:0];
   always_comb begin
      w_idx = '0;
      for (int i = N_REQ-1; i >= 0; i--)
         if (w_rot[i]) w_idx = ID_W'(i);
   end
   assign any     = |req;
   assign pick_id = any ? w_idx + ptr : '0;
   assign pick    = any ? N_REQ'(1) << pick_id : '0;
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with registered one-hot grant and hold-time preemption.
module rr_arbiter8
   import rr_arbiter8_pkg::*;
#(
   parameter int HOLD_MAX = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             gnt_valid
);
   state_t             r_state, w_state;
   logic [ID_W-1:0]    r_ptr, w_ptr, w_pick_id, w_id;
   logic [HOLD_W-1:0]  r_hold, w_hold;
   logic [N_REQ-1:0]   r_gnt, w_gnt, w_pick;
   logic [ID_W-1:0]    r_gnt_id;
   logic               r_gnt_valid, w_any, w_own, w_others, w_take, w_revoke, w_keep;
   rr_pick8 u_pick (.req(req), .ptr(r_ptr), .pick(w_pick), .pick_id(w_pick_id), .any(w_any));
   always_comb begin
      w_own    = |(req & r_gnt);
      w_others = |(req & ~r_gnt);
      // a released owner's bit is already low, so the picker skips it
      w_take   = (r_state == IDLE || !w_own) && w_any;
      w_revoke = r_state == GRANT && w_own && w_others && r_hold == HOLD_W'(HOLD_MAX-1);
      w_keep   = r_state == GRANT && w_own && !w_revoke;
      w_state  = (w_take || w_keep) ? GRANT : IDLE;
      w_gnt    = w_take ? w_pick : w_keep ? r_gnt : '0;
      w_id     = w_take ? w_pick_id : w_keep ? r_gnt_id : '0;
      w_ptr    = w_take ? w_pick_id + ID_W'(1) : r_ptr;
      w_hold   = w_take ? '0 : (w_keep && r_hold != HOLD_W'(HOLD_MAX)) ? r_hold + HOLD_W'(1) : r_hold;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_hold      <= '0;
         r_gnt       <= '0;
         r_gnt_id    <= '0;
         r_gnt_valid <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_ptr       <= w_ptr;
         r_hold      <= w_hold;
         r_gnt       <= w_gnt;
         r_gnt_id    <= w_id;
         r_gnt_valid <= w_take || w_keep;
      end
   end
   assign gnt       = r_gnt;
   assign gnt_id    = r_gnt_id;
   assign gnt_valid = r_gnt_valid;
endmodule
